// File: rtl/exe_mem_pipe_pkg.sv
// Shared definitions for the EXE->MEM pipeline register: memory op
// encodings, the zero register index, default widths and the alignment
// helper used by the optional misalignment check.
package exe_mem_pipe_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int RDATA_W_DEF = 32;
  localparam int OP_W_DEF    = 4;

  typedef enum logic [OP_W_DEF-1:0] {
    MEM_NOP = 4'h0,
    MEM_LB  = 4'h1,
    MEM_LH  = 4'h2,
    MEM_LW  = 4'h3,
    MEM_LBU = 4'h4,
    MEM_LHU = 4'h5,
    MEM_SB  = 4'h6,
    MEM_SH  = 4'h7,
    MEM_SW  = 4'h8
  } mem_op_e;

  localparam logic [RADDR_W_DEF-1:0] ZERO_REG = '0;

  // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [OP_W_DEF-1:0] op,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = addr_lo[0];
      MEM_LW, MEM_SW:          mis = |addr_lo;
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/exe_mem_pipe_entry.sv
// One pipeline slot: a payload register plus its valid bit.
// Clear wins over set so a flush always empties the slot.
module exe_mem_entry #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         set_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Next state: payload only changes on a load, so it holds after a clear.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (set_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/exe_mem_pipe.sv
// EXE->MEM pipeline register built as a two-entry skid buffer.
// The main entry drives the outputs; the skid entry catches one extra
// beat so in_ready_o is purely registered (no path from out_ready_i).
// Optional feature: define EXE_MEM_MISALIGN_CHK_EN to add misalign_o and
// suppress stores whose address is not aligned to the access size.
module exe_mem_pipe
  import exe_mem_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int RADDR_WIDTH = RADDR_W_DEF,
  parameter int RDATA_WIDTH = RDATA_W_DEF,
  parameter int OP_WIDTH    = OP_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [OP_WIDTH-1:0]    mem_op_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_data_o,
  output logic [OP_WIDTH-1:0]    mem_op_o,
  output logic [1:0]             occ_o
`ifdef EXE_MEM_MISALIGN_CHK_EN
  ,
  output logic                   misalign_o
`endif
);

  localparam int PW = RADDR_WIDTH + 1 + RDATA_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH + OP_WIDTH;
`ifdef EXE_MEM_MISALIGN_CHK_EN
  localparam int EW = PW + 1;
`else
  localparam int EW = PW;
`endif

  localparam logic [PW-1:0] PAY_RST = {RADDR_WIDTH'(ZERO_REG), 1'b0, RDATA_WIDTH'(0), 1'b0,
                                       ADDR_WIDTH'(0), DATA_WIDTH'(0), OP_WIDTH'(MEM_NOP)};
  localparam logic [EW-1:0] ENT_RST = EW'(PAY_RST);

  logic          main_v, skid_v;
  logic [EW-1:0] main_data, skid_data, in_data, main_in;
  logic          xfer_in, xfer_out;
  logic          main_set, main_clr, skid_set, skid_clr;

  logic [RADDR_WIDTH-1:0] h_waddr;
  logic                   h_rwe;
  logic [RDATA_WIDTH-1:0] h_rwdata;
  logic                   h_mwe;
  logic [ADDR_WIDTH-1:0]  h_maddr;
  logic [DATA_WIDTH-1:0]  h_mdata;
  logic [OP_WIDTH-1:0]    h_op;
  logic                   h_mis;

`ifdef EXE_MEM_MISALIGN_CHK_EN
  assign in_data = {is_misaligned(mem_op_i, mem_addr_i[1:0]),
                    reg_waddr_i, reg_we_i, reg_wdata_i,
                    mem_we_i, mem_addr_i, mem_data_i, mem_op_i};
  assign h_mis   = main_data[EW-1];
`else
  assign in_data = {reg_waddr_i, reg_we_i, reg_wdata_i,
                    mem_we_i, mem_addr_i, mem_data_i, mem_op_i};
  assign h_mis   = 1'b0;
`endif

  assign {h_waddr, h_rwe, h_rwdata, h_mwe, h_maddr, h_mdata, h_op} = main_data[PW-1:0];

  assign in_ready_o = ~skid_v;
  assign xfer_in    = in_valid_i & ~skid_v;
  assign xfer_out   = main_v & out_ready_i;

  // Slot control: skid refills main first; input goes to main when main is
  // free or draining this cycle, otherwise into skid. Flush blocks all loads.
  always_comb begin
    main_set = 1'b0;
    main_clr = 1'b0;
    skid_set = 1'b0;
    skid_clr = 1'b0;
    main_in  = in_data;
    if (flush_i) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      if (skid_v && xfer_out) begin
        main_set = 1'b1;
        main_in  = skid_data;
        skid_clr = 1'b1;
      end else if (xfer_in && (!main_v || xfer_out)) begin
        main_set = 1'b1;
      end else if (xfer_out) begin
        main_clr = 1'b1;
      end
      if (xfer_in && main_v && !xfer_out) begin
        skid_set = 1'b1;
      end
    end
  end

  exe_mem_entry #(.W(EW), .RST_VAL(ENT_RST)) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .set_i   (main_set),
    .clr_i   (main_clr),
    .data_i  (main_in),
    .valid_o (main_v),
    .data_o  (main_data)
  );

  exe_mem_entry #(.W(EW), .RST_VAL(ENT_RST)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .set_i   (skid_set),
    .clr_i   (skid_clr),
    .data_i  (in_data),
    .valid_o (skid_v),
    .data_o  (skid_data)
  );

  // Head outputs: enables and op are masked when empty, data fields hold.
  always_comb begin
    out_valid_o = main_v;
    reg_waddr_o = h_waddr;
    reg_wdata_o = h_rwdata;
    mem_addr_o  = h_maddr;
    mem_data_o  = h_mdata;
    reg_we_o    = main_v & h_rwe;
    mem_we_o    = main_v & h_mwe & ~h_mis;
    mem_op_o    = main_v ? h_op : OP_WIDTH'(MEM_NOP);
    occ_o       = {1'b0, main_v} + {1'b0, skid_v};
  end

`ifdef EXE_MEM_MISALIGN_CHK_EN
  assign misalign_o = main_v & h_mis;
`endif

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Testbench for exe_mem_pipe: directed scenarios followed by random traffic,
// checked every cycle against a two-deep FIFO reference model.
module tb_exe_mem_pipe;
  import exe_mem_pipe_pkg::*;

  typedef struct packed {
    logic [4:0]  waddr;
    logic        rwe;
    logic [31:0] rwdata;
    logic        mwe;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  op;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic        reg_we_i, reg_we_o, mem_we_i, mem_we_o;
  logic [31:0] reg_wdata_i, reg_wdata_o, mem_addr_i, mem_addr_o, mem_data_i, mem_data_o;
  logic [3:0]  mem_op_i, mem_op_o;
  logic [1:0]  occ_o;
`ifdef EXE_MEM_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  always #5 clk_i = ~clk_i;

  exe_mem_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_op_i(mem_op_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_op_o(mem_op_o),
    .occ_o(occ_o)
`ifdef EXE_MEM_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );

  ent_t q[$];
  ent_t last_head;
  ent_t cur;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic ent_t rst_ent();
    ent_t e;
    e       = '0;
    e.waddr = ZERO_REG;
    e.op    = MEM_NOP;
    return e;
  endfunction

  function automatic ent_t rand_ent(input int tag);
    ent_t e;
    e.waddr  = 5'($urandom);
    e.rwe    = 1'($urandom);
    e.rwdata = {16'(tag), 16'($urandom)};
    e.mwe    = 1'($urandom);
    e.addr   = $urandom;
    e.data   = $urandom;
    e.op     = 4'($urandom_range(0, 8));
    return e;
  endfunction

  function automatic bit mis_of(input ent_t e);
`ifdef EXE_MEM_MISALIGN_CHK_EN
    if (e.op == MEM_LH || e.op == MEM_LHU || e.op == MEM_SH) return (e.addr % 2) != 0;
    if (e.op == MEM_LW || e.op == MEM_SW) return (e.addr % 4) != 0;
    return 1'b0;
`else
    return (e.waddr == 5'd0) && (e.waddr != 5'd0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl, input logic rs);
    cur         = e;
    in_valid_i  = v;
    out_ready_i = ordy;
    flush_i     = fl;
    rst_i       = rs;
    reg_waddr_i = e.waddr;
    reg_we_i    = e.rwe;
    reg_wdata_i = e.rwdata;
    mem_we_i    = e.mwe;
    mem_addr_i  = e.addr;
    mem_data_i  = e.data;
    mem_op_i    = e.op;
  endtask

  task automatic check_all();
    bit ov;
    ov = q.size() > 0;
    chk("out_valid", out_valid_o, ov);
    chk("in_ready",  in_ready_o,  q.size() < 2);
    chk("occ",       occ_o,       q.size());
    chk("reg_waddr", reg_waddr_o, last_head.waddr);
    chk("reg_wdata", reg_wdata_o, last_head.rwdata);
    chk("mem_addr",  mem_addr_o,  last_head.addr);
    chk("mem_data",  mem_data_o,  last_head.data);
    chk("reg_we",    reg_we_o,    ov && last_head.rwe);
    chk("mem_we",    mem_we_o,    ov && last_head.mwe && !mis_of(last_head));
    chk("mem_op",    mem_op_o,    ov ? last_head.op : MEM_NOP);
`ifdef EXE_MEM_MISALIGN_CHK_EN
    chk("misalign",  misalign_o,  ov && mis_of(last_head));
`endif
  endtask

  // One clock: the model applies the stage's queue semantics to the
  // inputs held across the edge, then every output is compared.
  task automatic tick();
    bit can_in, do_out;
    @(posedge clk_i);
    if (rst_i) begin
      q.delete();
      last_head = rst_ent();
    end else if (flush_i) begin
      q.delete();
    end else begin
      can_in = q.size() < 2;
      do_out = (q.size() > 0) && out_ready_i;
      if (do_out) void'(q.pop_front());
      if (in_valid_i && can_in) q.push_back(cur);
    end
    if (q.size() > 0) last_head = q[0];
    #1;
    check_all();
  endtask

  initial begin
    ent_t a, b, e;
    last_head = rst_ent();
    drive(1'b0, rst_ent(), 1'b0, 1'b0, 1'b1);

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_mem_op",   mem_op_o,   MEM_NOP);

    // Streaming: eight back-to-back entries, consumer always ready
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rand_ent(i), 1'b1, 1'b0, 1'b0);
      tick();
      chk("stream_occ_le1", occ_o <= 2'd1, 1'b1);
      chk("stream_order",   reg_wdata_o[31:16], 16'(i));
    end
    drive(1'b0, rand_ent(99), 1'b1, 1'b0, 1'b0);
    tick();

    // Backpressure: A and B offered while stalled
    a = rand_ent(16'hA);
    b = rand_ent(16'hB);
    drive(1'b1, a, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, b, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, rand_ent(1), 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_occ2",     occ_o,       2'd2);
    chk("bp_ready0",   in_ready_o,  1'b0);
    chk("bp_head_a",   reg_wdata_o, a.rwdata);
    drive(1'b0, rand_ent(2), 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_head_b",   reg_wdata_o, b.rwdata);
    chk("bp_ready1",   in_ready_o,  1'b1);
    tick();
    chk("bp_drained",  out_valid_o, 1'b0);

    // Flush with a simultaneous offer while full
    drive(1'b1, rand_ent(3), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, rand_ent(4), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, rand_ent(5), 1'b0, 1'b1, 1'b0);
    tick();
    chk("flush_occ",    occ_o,       2'd0);
    chk("flush_valid",  out_valid_o, 1'b0);
    chk("flush_mem_we", mem_we_o,    1'b0);
    drive(1'b0, rand_ent(6), 1'b0, 1'b0, 1'b0);
    tick();
    chk("flush_ready",  in_ready_o,  1'b1);

    // Reset while stalled with two entries held
    drive(1'b1, rand_ent(7), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, rand_ent(8), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, rand_ent(9), 1'b1, 1'b0, 1'b1);
    tick();
    chk("rst_mid_occ",   occ_o,       2'd0);
    chk("rst_mid_waddr", reg_waddr_o, ZERO_REG);
    chk("rst_mid_wdata", reg_wdata_o, 32'd0);

`ifdef EXE_MEM_MISALIGN_CHK_EN
    // Misaligned and aligned word stores
    e      = rand_ent(10);
    e.op   = MEM_SW;
    e.mwe  = 1'b1;
    e.addr = 32'h1002;
    drive(1'b1, e, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mis_flag_set", misalign_o, 1'b1);
    chk("mis_store_off", mem_we_o,  1'b0);
    e.addr = 32'h1004;
    drive(1'b1, e, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mis_flag_clr", misalign_o, 1'b0);
    chk("mis_store_on", mem_we_o,   1'b1);
    drive(1'b0, e, 1'b1, 1'b0, 1'b0);
    tick();
`else
    // Without the check a misaligned store still writes
    e      = rand_ent(10);
    e.op   = MEM_SW;
    e.mwe  = 1'b1;
    e.addr = 32'h1002;
    drive(1'b1, e, 1'b0, 1'b0, 1'b0);
    tick();
    chk("noc_store_on", mem_we_o, 1'b1);
    drive(1'b0, e, 1'b1, 1'b0, 1'b0);
    tick();
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, rand_ent(100 + i), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
